// File: rtl/fft_bitrev_reader.sv
// rtl/fft_bitrev_reader.sv - bit-reversed read address sequencer for one N-point FFT frame
// Optional back-to-back frame streaming: define FFT_BITREV_CONTINUOUS_EN.
module fft_bitrev_reader #(
  parameter int LOG2N = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sclr,
  input  logic             start,
  input  logic             rd_ready,
  output logic             rd_valid,
  output logic [LOG2N-1:0] rd_addr,
  output logic [LOG2N-1:0] rd_idx,
  output logic             last,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [LOG2N-1:0] LAST_IDX = '1;

  state_t           state_q, state_d;
  logic [LOG2N-1:0] index_q, index_d;
  logic             done_q, done_d;
  logic             xfer;
  logic             at_last;

  assign xfer    = (state_q == S_RUN) && rd_ready;
  assign at_last = (index_q == LAST_IDX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      index_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    index_d = index_q;
    done_d  = 1'b0;
    if (sclr) begin
      state_d = S_IDLE;
      index_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d = S_RUN;
            index_d = '0;
          end
        end
        S_RUN: begin
          if (xfer) begin
            index_d = index_q + LOG2N'(1);
            if (at_last) begin
              done_d = 1'b1;
`ifndef FFT_BITREV_CONTINUOUS_EN
              state_d = S_DONE;
`endif
            end
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Every output is a function of flops only, so rd_ready never reaches rd_addr.
  always_comb begin
    rd_valid = (state_q == S_RUN);
    busy     = (state_q == S_RUN);
    done     = done_q;
    rd_idx   = rd_valid ? index_q : '0;
    last     = rd_valid && at_last;
    rd_addr  = '0;
    for (int i = 0; i < LOG2N; i++) begin
      rd_addr[i] = rd_idx[LOG2N-1-i];
    end
  end

endmodule

// File: tb/tb_fft_bitrev_reader.sv
// tb/tb_fft_bitrev_reader.sv - randomized self-checking bench for fft_bitrev_reader
// Build with FFT_BITREV_CONTINUOUS_EN defined to exercise streaming mode.
module tb_fft_bitrev_reader;

  localparam int LOG2N = 3;
  localparam int N     = 1 << LOG2N;
  localparam int W     = 4 + 2 * LOG2N;

  logic             clk;
  logic             rst_n;
  logic             sclr;
  logic             start;
  logic             rd_ready;
  logic             rd_valid;
  logic [LOG2N-1:0] rd_addr;
  logic [LOG2N-1:0] rd_idx;
  logic             last;
  logic             busy;
  logic             done;
  logic [W-1:0]     obs;

  int checks_total;
  int checks_passed;

  fft_bitrev_reader #(.LOG2N(LOG2N)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .sclr     (sclr),
    .start    (start),
    .rd_ready (rd_ready),
    .rd_valid (rd_valid),
    .rd_addr  (rd_addr),
    .rd_idx   (rd_idx),
    .last     (last),
    .busy     (busy),
    .done     (done)
  );

  assign obs = {rd_valid, busy, done, last, rd_idx, rd_addr};

  always #5 clk = ~clk;

  // Reference bit reversal: read index bits LSB first, shift them into the result.
  function automatic logic [LOG2N-1:0] bitrev(int v);
    int r;
    r = 0;
    for (int i = 0; i < LOG2N; i++) r = r * 2 + ((v >> i) & 1);
    return LOG2N'(r);
  endfunction

  function automatic logic [W-1:0] expv(logic v, logic b, logic d, logic l, int idx);
    logic [LOG2N-1:0] ix;
    ix = LOG2N'(idx);
    return {v, b, d, l, ix, bitrev(idx)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic leave_run();
    sclr = 1'b1;
    tick();
    sclr = 1'b0;
    rd_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; sclr = 1'b0; start = 1'b0; rd_ready = 1'b0;
    #13;
    checks_total++;
    if (obs !== expv(0, 0, 0, 0, 0))
      $display("FAIL reset_hold: got %h expected %h", obs, expv(0, 0, 0, 0, 0));
    else checks_passed++;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checks_total++;
    if (obs !== expv(0, 0, 0, 0, 0))
      $display("FAIL reset_release: got %h expected %h", obs, expv(0, 0, 0, 0, 0));
    else checks_passed++;
  endtask

  task automatic test_basic();
    start = 1'b1; rd_ready = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < N; k++) begin
      checks_total++;
      if (obs !== expv(1, 1, 0, k == N - 1, k))
        $display("FAIL basic_beat %0d: got %h expected %h", k, obs, expv(1, 1, 0, k == N - 1, k));
      else checks_passed++;
      tick();
    end
    checks_total++;
    if (obs !== expv(0, 0, 1, 0, 0))
      $display("FAIL basic_done: got %h expected %h", obs, expv(0, 0, 1, 0, 0));
    else checks_passed++;
    tick();
    checks_total++;
    if (obs !== expv(0, 0, 0, 0, 0))
      $display("FAIL basic_idle: got %h expected %h", obs, expv(0, 0, 0, 0, 0));
    else checks_passed++;
    rd_ready = 1'b0;
  endtask

  task automatic test_stall();
    int  k, post, ndone;
    bit  justfin, rdy;
    k = 0; post = 0; ndone = 0; justfin = 0;
    start = 1'b1; rd_ready = 1'b0;
    tick();
    start = 1'b0;
    for (int c = 0; c < 200; c++) begin
      checks_total++;
      if (obs !== expv(k < N, k < N, justfin, k == N - 1, (k < N) ? k : 0))
        $display("FAIL stall_cycle %0d: got %h expected %h", c, obs,
                 expv(k < N, k < N, justfin, k == N - 1, (k < N) ? k : 0));
      else checks_passed++;
      if (done) ndone++;
      if (k == N && post >= 3) break;
      rdy = (c < 12) ? (c % 3 == 0) : 1'($urandom_range(0, 1));
      rd_ready = rdy;
      tick();
      justfin = 0;
      if (k < N && rdy) begin
        k++;
        if (k == N) justfin = 1;
      end else if (k == N) begin
        post++;
      end
    end
    rd_ready = 1'b0;
    checks_total++;
    if (k !== N) $display("FAIL stall_beats: got %0d expected %0d", k, N);
    else checks_passed++;
    checks_total++;
    if (ndone !== 1) $display("FAIL stall_done_count: got %0d expected 1", ndone);
    else checks_passed++;
  endtask

  task automatic test_sclr();
    start = 1'b1; rd_ready = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    checks_total++;
    if (obs !== expv(1, 1, 0, 0, 3))
      $display("FAIL sclr_pre: got %h expected %h", obs, expv(1, 1, 0, 0, 3));
    else checks_passed++;
    sclr = 1'b1;
    tick();
    sclr = 1'b0;
    for (int c = 0; c < 5; c++) begin
      checks_total++;
      if (obs !== expv(0, 0, 0, 0, 0))
        $display("FAIL sclr_idle %0d: got %h expected %h", c, obs, expv(0, 0, 0, 0, 0));
      else checks_passed++;
      tick();
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    checks_total++;
    if (obs !== expv(1, 1, 0, 0, 0))
      $display("FAIL sclr_restart: got %h expected %h", obs, expv(1, 1, 0, 0, 0));
    else checks_passed++;
    leave_run();
  endtask

  task automatic test_async_reset();
    start = 1'b1; rd_ready = 1'b1;
    tick();
    start = 1'b0;
    repeat (2) tick();
    #2;
    rst_n = 1'b0;
    #1;
    checks_total++;
    if (obs !== expv(0, 0, 0, 0, 0))
      $display("FAIL async_reset: got %h expected %h", obs, expv(0, 0, 0, 0, 0));
    else checks_passed++;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    checks_total++;
    if (obs !== expv(1, 1, 0, 0, 0))
      $display("FAIL async_restart0: got %h expected %h", obs, expv(1, 1, 0, 0, 0));
    else checks_passed++;
    tick();
    checks_total++;
    if (obs !== expv(1, 1, 0, 0, 1))
      $display("FAIL async_restart1: got %h expected %h", obs, expv(1, 1, 0, 0, 1));
    else checks_passed++;
    leave_run();
  endtask

  task automatic test_start_ignored();
    int beats, ndone;
    beats = 0; ndone = 0;
    start = 1'b1; rd_ready = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 30; c++) begin
      if (rd_valid) beats++;
      if (done) ndone++;
      start = (c == 3) || (c == int'($urandom_range(4, 6))) || done;
      tick();
      start = 1'b0;
    end
    checks_total++;
    if (beats !== N) $display("FAIL ignore_beats: got %0d expected %0d", beats, N);
    else checks_passed++;
    checks_total++;
    if (ndone !== 1) $display("FAIL ignore_done_count: got %0d expected 1", ndone);
    else checks_passed++;
    checks_total++;
    if (obs !== expv(0, 0, 0, 0, 0))
      $display("FAIL ignore_idle: got %h expected %h", obs, expv(0, 0, 0, 0, 0));
    else checks_passed++;
    start = 1'b1; sclr = 1'b1;
    tick();
    start = 1'b0; sclr = 1'b0;
    for (int c = 0; c < 2; c++) begin
      checks_total++;
      if (obs !== expv(0, 0, 0, 0, 0))
        $display("FAIL start_with_sclr %0d: got %h expected %h", c, obs, expv(0, 0, 0, 0, 0));
      else checks_passed++;
      tick();
    end
    rd_ready = 1'b0;
  endtask

  task automatic test_continuous();
    start = 1'b1; rd_ready = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 20; c++) begin
      checks_total++;
      if (obs !== expv(1, 1, (c >= N) && (c % N == 0), c % N == N - 1, c % N))
        $display("FAIL cont_cycle %0d: got %h expected %h", c, obs,
                 expv(1, 1, (c >= N) && (c % N == 0), c % N == N - 1, c % N));
      else checks_passed++;
      tick();
    end
    leave_run();
    checks_total++;
    if (obs !== expv(0, 0, 0, 0, 0))
      $display("FAIL cont_sclr: got %h expected %h", obs, expv(0, 0, 0, 0, 0));
    else checks_passed++;
  endtask

  initial begin
    clk = 1'b0;
    checks_total = 0;
    checks_passed = 0;
    test_reset();
`ifdef FFT_BITREV_CONTINUOUS_EN
    test_continuous();
`else
    test_basic();
    test_stall();
    test_start_ignored();
`endif
    test_sclr();
    test_async_reset();
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
